// File: rtl/dm_lsu_pkg.sv
// Shared encodings for the data-memory load/store unit.
package dm_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // A dword access only exists on a 64-bit datapath.
  function automatic logic size_illegal(input logic [1:0] sz, input int dw);
    return (sz == SZ_D) && (dw == 32);
  endfunction

endpackage

// File: rtl/dm_lsu_if.sv
// CPU request/response and memory port bundle for dm_lsu.
interface dm_lsu_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  logic [1:0]            req_size;
  logic                  req_sign;
  logic [DATA_W-1:0]     req_wdata;
  logic                  mem_en;
  logic [DATA_W/8-1:0]   mem_be;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_data;
  logic                  rsp_err;

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_sign, req_wdata,
    input  mem_rdata, rsp_ready,
    output req_ready, mem_en, mem_be, mem_addr, mem_wdata,
    output rsp_valid, rsp_data, rsp_err
  );

  modport master (
    output req_valid, req_we, req_addr, req_size, req_sign, req_wdata,
    output mem_rdata, rsp_ready,
    input  req_ready, mem_en, mem_be, mem_addr, mem_wdata,
    input  rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/dm_lsu_ext.sv
// Load lane select and sign/zero extension; purely combinational.
module dm_lsu_ext #(
  parameter int DATA_W = 32,
  localparam int OFF_W = $clog2(DATA_W/8)
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [OFF_W-1:0]  off,
  input  logic [1:0]        size,
  input  logic              sign,
  output logic [DATA_W-1:0] data
);
  logic [DATA_W-1:0] shifted, mask, top;
  logic [6:0]        nb;

  always_comb begin
    shifted = rdata >> {off, 3'b000};
    nb      = 7'd8 << size;
    if (nb >= 7'(DATA_W)) mask = '1;
    else                  mask = (DATA_W'(1) << nb) - DATA_W'(1);
    // top isolates the lane MSB, which is the sign bit
    top  = mask ^ (mask >> 1);
    data = shifted & mask;
    if (sign && |(shifted & top)) data = data | ~mask;
  end
endmodule

// File: rtl/dm_lsu.sv
// Single-outstanding load/store unit: IDLE accepts, WAIT captures load data, RESP holds the result.
module dm_lsu
  import dm_lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input logic     clk,
  input logic     reset,
  dm_lsu_if.slave bus
);
  localparam int NB    = DATA_W/8;
  localparam int OFF_W = $clog2(NB);

  state_e               state, nxt;
  logic [OFF_W-1:0]     off, sz_mask, ld_off;
  logic [1:0]           ld_size;
  logic                 ld_sign;
  logic                 idle, accept, err, legal;
  logic [NB-1:0]        be_lane;
  logic [NB-1:0][7:0]   wbytes, wrep;
  logic [DATA_W-1:0]    ext_data;

  assign off = bus.req_addr[OFF_W-1:0];

  always_comb begin
    case (bus.req_size)
      SZ_B:    sz_mask = '0;
      SZ_H:    sz_mask = OFF_W'(1);
      SZ_W:    sz_mask = OFF_W'(3);
      default: sz_mask = '1;
    endcase
  end

  assign idle   = (state == IDLE);
  assign err    = size_illegal(bus.req_size, DATA_W) | (|(off & sz_mask));
  assign accept = idle & bus.req_valid & ~reset;
  assign legal  = accept & ~err;

  assign bus.req_ready = idle & ~reset;
  assign bus.mem_en    = legal;
  assign bus.mem_addr  = {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign bus.rsp_valid = (state == RESP);
  assign wbytes        = bus.req_wdata;

  // A lane is written when it shares the access's naturally aligned group;
  // its data is the low store byte matching its position within that group.
  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign be_lane[i] = ~|((OFF_W'(i) ^ off) & ~sz_mask);
    assign wrep[i]    = wbytes[OFF_W'(i) & sz_mask];
  end

  assign bus.mem_be    = (legal & bus.req_we) ? be_lane : '0;
  assign bus.mem_wdata = wrep;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = (err | bus.req_we) ? RESP : WAIT;
      WAIT:    nxt = RESP;
      RESP:    if (bus.rsp_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rsp_data <= '0;
      bus.rsp_err  <= 1'b0;
      ld_off       <= '0;
      ld_size      <= '0;
      ld_sign      <= 1'b0;
    end else if (accept) begin
      bus.rsp_data <= '0;
      bus.rsp_err  <= err;
      ld_off       <= off;
      ld_size      <= bus.req_size;
      ld_sign      <= bus.req_sign;
    end else if (state == WAIT) begin
      bus.rsp_data <= ext_data;
    end
  end

  dm_lsu_ext #(.DATA_W(DATA_W)) u_ext (
    .rdata (bus.mem_rdata),
    .off   (ld_off),
    .size  (ld_size),
    .sign  (ld_sign),
    .data  (ext_data)
  );
endmodule

// File: tb/tb_dm_lsu.sv
// Randomized scoreboard bench for dm_lsu (DATA_W=32).
module tb_dm_lsu;
  logic clk, reset;
  int   cyc = 0;
  int   checks = 0, errors = 0;
  int   stall_until = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;
  exp_t q[$];

  dm_lsu_if #(.DATA_W(32), .ADDR_W(32)) bus();

  dm_lsu #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // Reference: pick the addressed bytes, then apply two's-complement arithmetic.
  function automatic logic [31:0] ref_load(input logic [31:0] addr, input int size,
                                           input bit sign, input logic [31:0] rd);
    longint v, m;
    int nb;
    nb = 1 << size;
    if (nb >= 4) return rd;
    m = (longint'(1) << (8*nb)) - 1;
    v = (longint'(rd) >> (8*int'(addr[1:0]))) & m;
    if (sign && v > m/2) v = v - (m + 1);
    return v[31:0];
  endfunction

  function automatic logic [3:0] ref_be(input logic [31:0] addr, input int size);
    int nb;
    nb = 1 << size;
    return 4'(((1 << nb) - 1) << int'(addr[1:0]));
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] wd, input int size);
    logic [31:0] o;
    int nb;
    nb = 1 << size;
    o = '0;
    for (int i = 0; i < 4; i++) o[8*i +: 8] = wd[8*(i % nb) +: 8];
    return o;
  endfunction

  // Called at posedge+1; returns at posedge+1.
  task automatic do_req(input bit we, input logic [31:0] addr, input int size, input bit sign,
                        input logic [31:0] wdata, input logic [31:0] rdata);
    int   n, nb;
    bit   e;
    exp_t x;
    nb = 1 << size;
    e  = (size == 3) || (int'(addr[2:0]) % nb != 0);
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_size  = 2'(size);
    bus.req_sign  = sign;
    bus.req_wdata = wdata;
    bus.req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_accept_timeout: req_ready still 0 after %0d cycles", n);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      return;
    end
    x.acc  = cyc;
    x.err  = e;
    x.lat  = (e || we) ? 1 : 2;
    x.data = (e || we) ? 32'h0 : ref_load(addr, size, sign, rdata);
    chk("mem_en", 64'(bus.mem_en), 64'(!e));
    if (!e) begin
      chk("mem_addr", 64'(bus.mem_addr), 64'(addr & 32'hFFFF_FFFC));
      chk("mem_be", 64'(bus.mem_be), we ? 64'(ref_be(addr, size)) : 64'h0);
      if (we) chk("mem_wdata", 64'(bus.mem_wdata), 64'(ref_wdata(wdata, size)));
    end
    q.push_back(x);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.mem_rdata = rdata;
    if (!e && !we) begin
      @(negedge clk);
      chk("wait_mem_en", 64'(bus.mem_en), 64'h0);
      @(posedge clk); #1;
      bus.mem_rdata = $urandom;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL rsp_drain_timeout: %0d responses outstanding", q.size());
      q.delete();
    end
    @(posedge clk); #1;
  endtask

  // Response ready: random, except inside a forced stall window.
  initial begin
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.rsp_ready = (cyc < stall_until) ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compare every presented response against the scoreboard head.
  initial begin
    bit   first;
    exp_t e;
    first = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        if (q.size() == 0) begin
          chk("rsp_unexpected", 64'(bus.rsp_valid), 64'h0);
        end else begin
          e = q[0];
          if (first) chk("rsp_latency", 64'(cyc - e.acc), 64'(e.lat));
          chk("rsp_data", 64'(bus.rsp_data), 64'(e.data));
          chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
          chk("rsp_req_ready", 64'(bus.req_ready), 64'h0);
          chk("rsp_mem_en", 64'(bus.mem_en), 64'h0);
          first = 1'b0;
          if (bus.rsp_ready) begin
            void'(q.pop_front());
            first = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] addr, m;
    int          size, n;
    reset         = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_size  = '0;
    bus.req_sign  = 1'b0;
    bus.req_wdata = '0;
    bus.mem_rdata = '0;
    @(negedge clk);
    chk("reset_req_ready", 64'(bus.req_ready), 64'h0);
    chk("reset_mem_en", 64'(bus.mem_en), 64'h0);
    @(negedge clk);
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    chk("reset_rsp_data", 64'(bus.rsp_data), 64'h0);
    chk("reset_rsp_err", 64'(bus.rsp_err), 64'h0);
    @(posedge clk); #1;
    reset         = 1'b0;
    bus.req_valid = 1'b0;

    do_req(0, 32'h3, 0, 1, 32'h0, 32'h80FF_1234);
    do_req(0, 32'h2, 1, 0, 32'h0, 32'h8001_0000);
    do_req(1, 32'h1, 0, 0, 32'h0000_00AB, 32'h0);
    do_req(0, 32'h6, 2, 0, 32'h0, 32'h1234_5678);
    do_req(0, 32'h8, 3, 0, 32'h0, 32'h1234_5678);
    do_req(0, 32'h4, 2, 1, 32'h0, 32'h8765_4321);
    drain();

    // Long backpressure on a store response.
    stall_until = cyc + 6;
    do_req(1, 32'h102, 1, 0, 32'hCAFE_BEEF, 32'h0);
    stall_until = cyc + 5;
    do_req(0, 32'h7, 0, 0, 32'h0, 32'hF00D_0000);
    drain();

    for (int i = 0; i < 60; i++) begin
      size = $urandom_range(0, 3);
      addr = $urandom;
      m    = (32'd1 << size) - 32'd1;
      if ($urandom_range(0, 3) != 0) addr = addr & ~m;
      if ($urandom_range(0, 7) == 0) stall_until = cyc + $urandom_range(2, 5);
      do_req($urandom_range(0, 1), addr, size, $urandom_range(0, 1), $urandom, $urandom);
    end
    drain();

    // Reset while a load sits in WAIT: the response must vanish.
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h40;
    bus.req_size  = 2'd2;
    bus.req_sign  = 1'b0;
    bus.req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rst_test_accept", 64'(bus.mem_en), 64'h1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    reset         = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rst_gate_req_ready", 64'(bus.req_ready), 64'h0);
    chk("rst_gate_mem_en", 64'(bus.mem_en), 64'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'h1);
    chk("rst_rsp_data", 64'(bus.rsp_data), 64'h0);
    repeat (3) @(negedge clk);
    chk("rst_still_idle", 64'(bus.rsp_valid), 64'h0);
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      size = $urandom_range(0, 2);
      addr = $urandom & ~((32'd1 << size) - 32'd1);
      do_req($urandom_range(0, 1), addr, size, $urandom_range(0, 1), $urandom, $urandom);
    end
    drain();

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dm_lsu.md
DM_LSU -- requirements
Module: dm_lsu

Interface
REQ-001 DATA_W, 32, data/memory word width in bits, 32 or 64 only.
REQ-002 ADDR_W, 32, byte-address width.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  CPU access request present.
REQ-006 req_ready  output  1  block accepts a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  ADDR_W  byte address.
REQ-009 req_size  input  2  0 byte, 1 half, 2 word, 3 dword (DATA_W=64 only).
REQ-010 req_sign  input  1  load result sign-extended when 1, zero-extended when 0.
REQ-011 req_wdata  input  DATA_W  store data, right-justified.
REQ-012 mem_en  output  1  memory access strobe.
REQ-013 mem_be  output  DATA_W/8  byte write enables; all zero on reads.
REQ-014 mem_addr  output  ADDR_W  word-aligned address (low log2(DATA_W/8) bits zero).
REQ-015 mem_wdata  output  DATA_W  store data replicated into the addressed lanes.
REQ-016 mem_rdata  input  DATA_W  read data, valid exactly one cycle after mem_en with mem_be=0.
REQ-017 rsp_valid  output  1  response present.
REQ-018 rsp_ready  input  1  CPU consumes response.
REQ-019 rsp_data  output  DATA_W  extended load data; 0 for stores and errors.
REQ-020 rsp_err  output  1  misaligned address or illegal size.

Function
REQ-021 FSM states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-022 Acceptance = req_valid & req_ready in IDLE; request fields are sampled only in that cycle.
REQ-023 Error when addr not aligned to 2^req_size bytes, or req_size=3 with DATA_W=32; error requests SHALL NOT assert mem_en and go IDLE->RESP with rsp_err=1, rsp_data=0.
REQ-024 Legal load: acceptance cycle drives mem_en=1, mem_be=0, aligned mem_addr combinationally; IDLE->WAIT.
REQ-025 WAIT: lane selected by addr low bits and size, extended per req_sign, registered into rsp_data; WAIT->RESP; rsp_valid at acceptance+2.
REQ-026 Legal store: acceptance cycle drives mem_en=1, mem_be with 2^size ones at lane offset, mem_wdata = req_wdata low bytes replicated across all lanes; IDLE->RESP; rsp_valid at acceptance+1, rsp_data=0.
REQ-027 RESP: rsp_valid=1, rsp_data/rsp_err held stable until rsp_ready=1; then RESP->IDLE; new request accepted no earlier than the following cycle.
REQ-028 mem_en SHALL be 0 in WAIT, RESP and whenever no legal request is accepted.
REQ-029 req_size=DATA_W width load returns mem_rdata unmodified regardless of req_sign.
REQ-030 Extension: sign bit is the MSB of the selected lane; result width always DATA_W.

Reset
REQ-031 reset=1 SHALL force state IDLE, rsp_valid=0, rsp_data=0, rsp_err=0 at the next edge, and gate mem_en=0 and req_ready=0 in that cycle.
REQ-032 reset during WAIT or RESP SHALL discard the pending response; mem_rdata arriving after reset SHALL be ignored.

Structure
REQ-033 Shared package dm_lsu_pkg SHALL hold size encodings (SZ_B, SZ_H, SZ_W, SZ_D) and the state encoding.
REQ-034 Lane select/extend logic SHALL be a combinational sub-module dm_lsu_ext (parameter DATA_W), instantiated once in WAIT datapath.

Verification (DATA_W=32)
REQ-035 Load byte addr 0x3, sign=1, mem_rdata 0x80FF_1234 -> rsp_valid at T+2, rsp_data 0xFFFF_FF80, rsp_err 0.
REQ-036 Load half addr 0x2, sign=0, mem_rdata 0x8001_0000 -> rsp_data 0x0000_8001.
REQ-037 Store byte addr 0x1, wdata 0x0000_00AB -> mem_be 4'b0010, mem_wdata 0xABAB_ABAB, mem_addr 0x0, rsp_valid at T+1.
REQ-038 Load word addr 0x6 -> no mem_en, rsp_err 1, rsp_data 0 at T+1; req_size=3 likewise errors.
REQ-039 rsp_ready held 0 for 3 cycles in RESP -> rsp_valid/rsp_data stable, req_ready 0, mem_en 0 throughout.
REQ-040 reset asserted in WAIT -> next cycle IDLE, rsp_valid 0, req_ready 1 after reset drops, stale mem_rdata never appears on rsp_data.
